// File: rtl/mem_stage.sv
// MIPS memory-access stage: data memory with byte/half/word stores, load
// extraction with sign/zero extension, post-reset clear sweep and debug read.
module mem_stage #(
  parameter int BUS_SIZE       = 32,
  parameter int MEM_ADDR_SIZE  = 5,
  parameter int DMEM_ADDR_BITS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [2:0]                i_mem_rd_src,
  input  logic [1:0]                i_mem_wr_src,
  input  logic                      i_mem_write,
  input  logic                      i_wb,
  input  logic                      i_mem_to_reg,
  input  logic                      i_halt,
  input  logic [BUS_SIZE-1:0]       i_bus_b,
  input  logic [BUS_SIZE-1:0]       i_alu_result,
  input  logic [MEM_ADDR_SIZE-1:0]  i_addr_wr,
  input  logic [DMEM_ADDR_BITS-1:0] i_dbg_addr,
  output logic [BUS_SIZE-1:0]       o_mem_rd_data,
  output logic [BUS_SIZE-1:0]       o_alu_result,
  output logic                      o_wb,
  output logic                      o_mem_to_reg,
  output logic                      o_halt,
  output logic [MEM_ADDR_SIZE-1:0]  o_addr_wr,
  output logic [BUS_SIZE-1:0]       o_dbg_data,
  output logic                      o_busy,
  output logic                      o_misaligned,
  output logic                      o_sweep_state
);

  localparam int DEPTH = 1 << DMEM_ADDR_BITS;
  localparam int LANES = BUS_SIZE / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sweep_state_t;

  // Flow control: o_busy acts as a not-ready to the upstream pipeline. While it
  // is high no store is accepted and loads read zero; once it falls it never
  // rises again until reset, so every store presented afterwards is taken on
  // the edge it is presented (subject to i_enable and alignment).

  logic [BUS_SIZE-1:0]       mem [DEPTH];
  sweep_state_t              state;
  logic [DMEM_ADDR_BITS-1:0] counter;
  logic                      misaligned_q;

  logic [DMEM_ADDR_BITS-1:0] word_idx;
  logic [1:0]                lane;
  logic [BUS_SIZE-1:0]       rd_word;
  logic                      st_misaligned;
  logic                      ld_misaligned;
  logic                      store_we;
  logic [LANES-1:0]          st_be;
  logic [BUS_SIZE-1:0]       st_lanes;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [BUS_SIZE-1:0]       ld_ext;

  assign word_idx = i_alu_result[DMEM_ADDR_BITS+1:2];
  assign lane     = i_alu_result[1:0];
  assign rd_word  = mem[word_idx];

  // Store alignment: SB never faults, SH needs even address, SW (1x) needs word alignment.
  always_comb begin
    st_misaligned = 1'b0;
    case (i_mem_wr_src)
      2'b00:   st_misaligned = 1'b0;
      2'b01:   st_misaligned = lane[0];
      default: st_misaligned = (lane != 2'b00);
    endcase
  end

  always_comb begin
    ld_misaligned = 1'b0;
    case (i_mem_rd_src)
      3'b000, 3'b011: ld_misaligned = 1'b0;
      3'b001, 3'b100: ld_misaligned = lane[0];
      default:        ld_misaligned = (lane != 2'b00);
    endcase
  end

  // Lane data is replicated so each byte enable picks its own slice.
  always_comb begin
    st_be    = '0;
    st_lanes = i_bus_b;
    case (i_mem_wr_src)
      2'b00: begin
        st_be    = LANES'(1) << lane;
        st_lanes = {LANES{i_bus_b[7:0]}};
      end
      2'b01: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_lanes = {(LANES/2){i_bus_b[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_lanes = i_bus_b;
      end
    endcase
  end

  assign store_we = (state == ST_READY) && i_enable && i_mem_write && !st_misaligned;

  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[counter] <= '0;
    end else if (store_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (st_be[i]) mem[word_idx][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_CLEAR;
      counter      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == DMEM_ADDR_BITS'(DEPTH - 1)) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
      // Flag is sticky and ignores i_enable: a faulting access is reported even when frozen.
      if ((i_mem_write && st_misaligned) || (i_mem_to_reg && ld_misaligned))
        misaligned_q <= 1'b1;
    end
  end

  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (i_mem_rd_src)
      3'b000:  ld_ext = {{(BUS_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(BUS_SIZE-16){ld_half[15]}}, ld_half};
      3'b011:  ld_ext = {{(BUS_SIZE-8){1'b0}}, ld_byte};
      3'b100:  ld_ext = {{(BUS_SIZE-16){1'b0}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign o_busy        = (state == ST_CLEAR);
  assign o_sweep_state = state;
  assign o_misaligned  = misaligned_q;
  assign o_mem_rd_data = (o_busy || (i_mem_to_reg && ld_misaligned)) ? '0 : ld_ext;
  assign o_dbg_data    = mem[i_dbg_addr];

  assign o_wb          = i_wb & ~o_busy;
  assign o_halt        = i_halt;
  assign o_mem_to_reg  = i_mem_to_reg;
  assign o_alu_result  = i_alu_result;
  assign o_addr_wr     = i_addr_wr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: sweep timing, stores/loads, misalignment,
// wrap-around, enable freeze and mid-sweep reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  mem_rd_src;
  logic [1:0]  mem_wr_src;
  logic        mem_write;
  logic        wb;
  logic        mem_to_reg;
  logic        halt;
  logic [31:0] bus_b;
  logic [31:0] alu_result;
  logic [4:0]  addr_wr;
  logic [7:0]  dbg_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] alu_result_out;
  logic        wb_out;
  logic        mem_to_reg_out;
  logic        halt_out;
  logic [4:0]  addr_wr_out;
  logic [31:0] dbg_data;
  logic        busy;
  logic        misaligned;
  logic        sweep_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_stage dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable),
    .i_mem_rd_src(mem_rd_src), .i_mem_wr_src(mem_wr_src), .i_mem_write(mem_write),
    .i_wb(wb), .i_mem_to_reg(mem_to_reg), .i_halt(halt),
    .i_bus_b(bus_b), .i_alu_result(alu_result), .i_addr_wr(addr_wr),
    .i_dbg_addr(dbg_addr),
    .o_mem_rd_data(mem_rd_data), .o_alu_result(alu_result_out), .o_wb(wb_out),
    .o_mem_to_reg(mem_to_reg_out), .o_halt(halt_out), .o_addr_wr(addr_wr_out),
    .o_dbg_data(dbg_data), .o_busy(busy), .o_misaligned(misaligned),
    .o_sweep_state(sweep_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: compares the combinational load result mid-cycle
  always @(negedge clk) begin
    if (mem_to_reg) begin
      if (exp_q.size() == 0) chk("load_unexpected", mem_rd_data, 32'hxxxx_xxxx);
      else chk("load_data", mem_rd_data, exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_rd_src = 3'b010;
    mem_wr_src = 2'b10;
    bus_b      = '0;
    alu_result = '0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data,
                       input logic en);
    @(posedge clk); #1;
    alu_result = addr; mem_wr_src = sz; bus_b = data; mem_write = 1'b1; enable = en;
    @(posedge clk); #1;
    idle_inputs(); enable = 1'b1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] ty, input logic [31:0] exp);
    @(posedge clk); #1;
    alu_result = addr; mem_rd_src = ty; mem_to_reg = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic dbg_read(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx; #1;
    chk(tag, dbg_data, exp);
  endtask

  // Counts edges from now until o_busy falls; optionally presents a store at edge st_at.
  task automatic sweep_count(input string tag, input int st_at);
    int n;
    n = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      n = e;
      if (e == st_at - 1) begin
        alu_result = 32'h0C; bus_b = 32'hCAFE_F00D; mem_wr_src = 2'b10; mem_write = 1'b1;
      end
      if (e == st_at) idle_inputs();
      if (e == 255) chk({tag, "_busy_at_255"}, {31'b0, busy}, 32'd1);
      if (!busy) break;
    end
    chk({tag, "_sweep_edges"}, n, 32'd256);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; #2;
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_wb", {31'b0, wb_out}, 32'd0);
    mem_to_reg = 1'b1; #1;
    chk("rst_rd_data", mem_rd_data, 32'd0);
    mem_to_reg = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] raddr;
    rst = 1'b1; enable = 1'b1; wb = 1'b1; halt = 1'b0; addr_wr = 5'd7; dbg_addr = '0;
    idle_inputs();

    // sweep after reset, with a store attempted while busy
    do_reset();
    sweep_count("sweep1", 50);
    chk("wb_after_sweep", {31'b0, wb_out}, 32'd1);
    chk("addr_wr_pass", {27'b0, addr_wr_out}, 32'd7);
    dbg_read("busy_store_ignored", 8'd3, 32'd0);

    // preload a pattern, then reset and check it is cleared
    store(32'h000, 2'b10, 32'hA5A5_0001, 1'b1);
    store(32'h1FC, 2'b10, 32'hA5A5_007F, 1'b1);
    store(32'h3FC, 2'b10, 32'hA5A5_00FF, 1'b1);
    dbg_read("preload_127", 8'd127, 32'hA5A5_007F);
    do_reset();
    sweep_count("sweep2", 0);
    dbg_read("clr_w0", 8'd0, 32'd0);
    dbg_read("clr_w127", 8'd127, 32'd0);
    dbg_read("clr_w255", 8'd255, 32'd0);

    // word and byte stores, loads with extension
    store(32'h10, 2'b10, 32'hDEAD_BEEF, 1'b1);
    load(32'h10, 3'b010, 32'hDEAD_BEEF);
    store(32'h13, 2'b00, 32'h0000_00AA, 1'b1);
    load(32'h10, 3'b010, 32'hAAAD_BEEF);
    load(32'h13, 3'b000, 32'hFFFF_FFAA);
    load(32'h13, 3'b011, 32'h0000_00AA);
    load(32'h12, 3'b001, 32'hFFFF_AAAD);
    load(32'h10, 3'b100, 32'h0000_BEEF);
    store(32'h16, 2'b01, 32'h0000_8001, 1'b1);
    load(32'h14, 3'b010, 32'h8001_0000);

    // randomized word round trips
    for (int i = 0; i < 4; i++) begin
      rnd   = $urandom;
      raddr = {22'b0, 8'($urandom_range(32, 63)), 2'b00};
      store(raddr, 2'b10, rnd, 1'b1);
      load(raddr, 3'b010, rnd);
    end

    // misalignment
    store(32'h00, 2'b10, 32'hFFFF_FFFF, 1'b1);
    chk("mis_before", {31'b0, misaligned}, 32'd0);
    store(32'h11, 2'b10, 32'h1234_5678, 1'b1);
    chk("mis_set", {31'b0, misaligned}, 32'd1);
    dbg_read("mis_store_suppressed", 8'd4, 32'hAAAD_BEEF);
    load(32'h01, 3'b001, 32'd0);
    load(32'h13, 3'b000, 32'hFFFF_FFAA);
    chk("mis_sticky", {31'b0, misaligned}, 32'd1);

    // wrap-around and enable freeze
    store(32'h400, 2'b10, 32'h1111_1111, 1'b1);
    load(32'h000, 3'b010, 32'h1111_1111);
    store(32'h000, 2'b10, 32'h2222_2222, 1'b0);
    load(32'h000, 3'b010, 32'h1111_1111);

    // reset mid-sweep restarts the full count
    do_reset();
    chk("mis_cleared", {31'b0, misaligned}, 32'd0);
    for (int e = 0; e < 100; e++) begin
      @(posedge clk); #1;
    end
    chk("midsweep_busy", {31'b0, busy}, 32'd1);
    do_reset();
    sweep_count("sweep3", 50);
    dbg_read("sweep3_store_ignored", 8'd3, 32'd0);
    load(32'h0C, 3'b010, 32'd0);

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
